// File: rtl/dcache_wbuf.sv
// D-cache write-back buffer: holds one evicted line or uncached store, drains it as a
// 32-bit burst, and flags refill hazards. Optional forwarding build: DCACHE_WBUF_FWD_EN.
module dcache_wbuf #(
  parameter int WORDS    = 4,
  parameter int OFFSET_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbuf_we,
  input  logic [31:0]           wbuf_addr,
  input  logic [32*WORDS-1:0]   wbuf_line,
  input  logic                  wbuf_uncache,
  input  logic [3:0]            wbuf_wstrb,
  output logic                  wbuf_ready,
  output logic                  mem_wreq,
  output logic [31:0]           mem_waddr,
  output logic [7:0]            mem_wlen,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_wreq_ack,
  output logic [31:0]           mem_wdata,
  output logic                  mem_wvalid,
  output logic                  mem_wlast,
  input  logic                  mem_wready,
  input  logic                  mem_bvalid,
  input  logic [31:0]           chk_addr,
  output logic                  chk_hit,
`ifdef DCACHE_WBUF_FWD_EN
  output logic                  fwd_valid,
  output logic [32*WORDS-1:0]   fwd_line,
`endif
  output logic [1:0]            dbg_state
);

  // Handshakes: a request or beat transfers on the rising edge where both its valid
  // (mem_wreq / mem_wvalid) and its acceptance (mem_wreq_ack / mem_wready) are high;
  // valids and their payload hold steady until that edge.

  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [7:0] LINE_LEN = 8'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         addr_q;
  logic [32*WORDS-1:0] line_q;
  logic                unc_q;
  logic [3:0]          strb_q;
  logic                ready_q;
  logic                wreq_q;
  logic                wvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      unc_q    <= 1'b0;
      strb_q   <= '0;
      ready_q  <= 1'b1;
      wreq_q   <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wbuf_we) begin
            addr_q  <= wbuf_addr;
            line_q  <= wbuf_line;
            unc_q   <= wbuf_uncache;
            strb_q  <= wbuf_wstrb;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            wreq_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_wreq_ack) begin
            wreq_q   <= 1'b0;
            wvalid_q <= 1'b1;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (wvalid_q && mem_wready) begin
            cnt_q <= cnt_q + 1'b1;
            if (mem_wlast) begin
              wvalid_q <= 1'b0;
              state_q  <= RESP;
            end
          end
        end
        RESP: begin
          if (mem_bvalid) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbuf_ready = ready_q;
  assign mem_wreq   = wreq_q;
  assign mem_wvalid = wvalid_q;
  assign mem_waddr  = unc_q ? addr_q : {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign mem_wlen   = unc_q ? 8'd0 : LINE_LEN;
  assign mem_wstrb  = unc_q ? strb_q : 4'hF;
  assign mem_wlast  = wvalid_q && ({{(8-CNT_W){1'b0}}, cnt_q} == mem_wlen);
  assign dbg_state  = state_q;

  always_comb begin
    mem_wdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (cnt_q == CNT_W'(i)) mem_wdata = line_q[32*i +: 32];
    end
  end

  // Uncached entries cover a single word, so the hazard window narrows to [31:2].
  logic line_match;
  logic word_match;
  logic held_hit;
  logic unused_chk;

  assign line_match = (chk_addr[31:OFFSET_W] == addr_q[31:OFFSET_W]);
  assign word_match = (chk_addr[31:2] == addr_q[31:2]);
  assign held_hit   = (state_q != IDLE) && (unc_q ? word_match : line_match);
  assign unused_chk = ^chk_addr[1:0];

`ifdef DCACHE_WBUF_FWD_EN
  assign fwd_valid = held_hit & ~unc_q;
  assign fwd_line  = line_q;
  assign chk_hit   = held_hit & unc_q;
`else
  assign chk_hit   = held_hit;
`endif

endmodule
